// File: rtl/ch1_sweep_pkg.sv
// Shared types for the channel-1 frequency sweep sequencer.
package ch1_sweep_pkg;

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      SHIFT_H,
      SHIFT_L,
      CHECK,
      WRITE,
      LOAD2,
      SHIFT2_H,
      SHIFT2_L,
      CHECK2
   } sweep_state_t;

   typedef enum logic {
      SEQ_TICK,
      SEQ_TRIG
   } seq_kind_t;

   // A programmed period of 0 behaves as the longest period.
   localparam int SWEEP_PERIOD_ZERO_RELOAD = 8;

endpackage

// File: rtl/ch1_sweep_timer.sv
// Sweep period down-counter: reloads from NR10 period (0 counts as 8),
// decrements on each 128 Hz tick and flags expiry on the reload tick.
module ch1_sweep_timer
   import ch1_sweep_pkg::*;
#(
   parameter int SHIFT_W = 3
) (
   input  logic               clk,
   input  logic               apu_reset,
   input  logic               load,
   input  logic               tick,
   input  logic [SHIFT_W-1:0] period,
   output logic               expire
);

   // One extra bit so the zero-period reload value of 8 is representable.
   logic [SHIFT_W:0] timer;
   logic [SHIFT_W:0] reload_val;

   // Reload value with the zero-as-eight rule applied.
   always_comb begin
      reload_val = {1'b0, period};
      if (period == '0) reload_val = (SHIFT_W+1)'(SWEEP_PERIOD_ZERO_RELOAD);
   end

   // A trigger reload swallows a coincident tick.
   assign expire = tick && !load && (timer <= (SHIFT_W+1)'(1));

   // Counter register: trigger reload has priority over tick handling.
   always_ff @(posedge clk) begin
      if (apu_reset) begin
         timer <= '0;
      end else if (load) begin
         timer <= reload_val;
      end else if (tick) begin
         if (timer > (SHIFT_W+1)'(1)) timer <= timer - 1'b1;
         else                         timer <= reload_val;
      end
   end

endmodule

// File: rtl/ch1_sweep_ctrl.sv
// Channel-1 sweep sequencer: drives load/shift/update strobes for the sweep
// datapath and requests channel disable on adder overflow.
// Optional: define SWEEP_NEG_QUIRK_EN to disable the channel when NR10[3]
// is cleared after a negate-mode calculation (DMG behaviour).
module ch1_sweep_ctrl
   import ch1_sweep_pkg::*;
#(
   parameter int SHIFT_W       = 3,
   parameter int CLK_PER_SHIFT = 2
) (
   input  logic               clk,
   input  logic               apu_reset,
   input  logic               sweep_tick,
   input  logic               ch1_trigger,
   input  logic [SHIFT_W-1:0] sweep_period,
   input  logic               sweep_neg,
   input  logic [SHIFT_W-1:0] sweep_shift,
   input  logic               sum_ovf,
   output logic               ch1_ld_shift,
   output logic               ch1_shift_clk,
   output logic               ch1_freq_upd,
   output logic               ch1_ovf_off,
   output logic               sweep_busy
);

   localparam int LO_W = ($clog2(CLK_PER_SHIFT) < 1) ? 1 : $clog2(CLK_PER_SHIFT);

   sweep_state_t       state, state_nxt;
   seq_kind_t          kind, kind_nxt;
   logic [SHIFT_W-1:0] n_shift, n_nxt;
   logic [SHIFT_W-1:0] rem, rem_nxt;
   logic [LO_W-1:0]    lo_cnt, lo_nxt;
   logic               sweep_en, sweep_en_nxt;
   logic               timer_expire;
   logic               ld_s, clk_s, upd_s, ovf_s;
   logic               ovf_hit;

   ch1_sweep_timer #(.SHIFT_W(SHIFT_W)) u_timer (
      .clk       (clk),
      .apu_reset (apu_reset),
      .load      (ch1_trigger),
      .tick      (sweep_tick),
      .period    (sweep_period),
      .expire    (timer_expire)
   );

   // Subtraction cannot overflow, so the carry only matters when adding.
   assign ovf_hit = !sweep_neg && sum_ovf;

`ifdef SWEEP_NEG_QUIRK_EN
   logic neg_used, neg_used_nxt, neg_q;
   logic quirk_fire;

   assign quirk_fire = neg_q && !sweep_neg && neg_used && sweep_en;

   // Track negate-mode use and the previous NR10[3] for the 1->0 detect.
   always_ff @(posedge clk) begin
      if (apu_reset) begin
         neg_used <= 1'b0;
         neg_q    <= 1'b0;
      end else begin
         neg_used <= neg_used_nxt;
         neg_q    <= sweep_neg;
      end
   end
`endif

   // Sequencer state register.
   always_ff @(posedge clk) begin
      if (apu_reset) begin
         state    <= IDLE;
         kind     <= SEQ_TICK;
         n_shift  <= '0;
         rem      <= '0;
         lo_cnt   <= '0;
         sweep_en <= 1'b0;
      end else begin
         state    <= state_nxt;
         kind     <= kind_nxt;
         n_shift  <= n_nxt;
         rem      <= rem_nxt;
         lo_cnt   <= lo_nxt;
         sweep_en <= sweep_en_nxt;
      end
   end

   // Next-state and strobe decode; trigger overrides everything last.
   always_comb begin
      state_nxt    = state;
      kind_nxt     = kind;
      n_nxt        = n_shift;
      rem_nxt      = rem;
      lo_nxt       = lo_cnt;
      sweep_en_nxt = sweep_en;
      ld_s         = 1'b0;
      clk_s        = 1'b0;
      upd_s        = 1'b0;
      ovf_s        = 1'b0;
`ifdef SWEEP_NEG_QUIRK_EN
      neg_used_nxt = neg_used;
`endif

      case (state)
         IDLE: begin
            if (timer_expire && sweep_en && (sweep_period != '0)) begin
               state_nxt = LOAD;
               kind_nxt  = SEQ_TICK;
               n_nxt     = sweep_shift;
            end
         end
         LOAD, LOAD2: begin
            ld_s    = 1'b1;
            rem_nxt = n_shift;
            if (n_shift == '0) state_nxt = (state == LOAD) ? CHECK : CHECK2;
            else               state_nxt = (state == LOAD) ? SHIFT_H : SHIFT2_H;
         end
         SHIFT_H, SHIFT2_H: begin
            clk_s     = 1'b1;
            lo_nxt    = LO_W'(CLK_PER_SHIFT - 2);
            state_nxt = (state == SHIFT_H) ? SHIFT_L : SHIFT2_L;
         end
         SHIFT_L, SHIFT2_L: begin
            if (lo_cnt != '0) begin
               lo_nxt = lo_cnt - 1'b1;
            end else if (rem == SHIFT_W'(1)) begin
               state_nxt = (state == SHIFT_L) ? CHECK : CHECK2;
            end else begin
               rem_nxt   = rem - 1'b1;
               state_nxt = (state == SHIFT_L) ? SHIFT_H : SHIFT2_H;
            end
         end
         CHECK: begin
`ifdef SWEEP_NEG_QUIRK_EN
            if (sweep_neg) neg_used_nxt = 1'b1;
`endif
            if (ovf_hit) begin
               ovf_s        = 1'b1;
               sweep_en_nxt = 1'b0;
               state_nxt    = IDLE;
            end else if (kind == SEQ_TICK && n_shift != '0) begin
               state_nxt = WRITE;
            end else begin
               state_nxt = IDLE;
            end
         end
         WRITE: begin
            upd_s     = 1'b1;
            state_nxt = LOAD2;
         end
         CHECK2: begin
`ifdef SWEEP_NEG_QUIRK_EN
            if (sweep_neg) neg_used_nxt = 1'b1;
`endif
            if (ovf_hit) begin
               ovf_s        = 1'b1;
               sweep_en_nxt = 1'b0;
            end
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

`ifdef SWEEP_NEG_QUIRK_EN
      if (quirk_fire) begin
         ld_s         = 1'b0;
         clk_s        = 1'b0;
         upd_s        = 1'b0;
         ovf_s        = 1'b1;
         sweep_en_nxt = 1'b0;
         state_nxt    = IDLE;
      end
`endif

      if (ch1_trigger) begin
         ld_s         = 1'b0;
         clk_s        = 1'b0;
         upd_s        = 1'b0;
         ovf_s        = 1'b0;
         sweep_en_nxt = (sweep_period != '0) || (sweep_shift != '0);
`ifdef SWEEP_NEG_QUIRK_EN
         neg_used_nxt = 1'b0;
`endif
         if (sweep_shift != '0) begin
            state_nxt = LOAD;
            kind_nxt  = SEQ_TRIG;
            n_nxt     = sweep_shift;
         end else begin
            state_nxt = IDLE;
         end
      end
   end

   assign ch1_ld_shift  = ld_s  && !apu_reset;
   assign ch1_shift_clk = clk_s && !apu_reset;
   assign ch1_freq_upd  = upd_s && !apu_reset;
   assign ch1_ovf_off   = ovf_s && !apu_reset;
   assign sweep_busy    = (state != IDLE) && !apu_reset;

endmodule
